vram_arbiter: RTL
=================

# vram_arbiter

Single-port frame-buffer arbiter between VGA scan-out and a pixel writer, driven by the 800x600@60 timing generator on the 40 MHz pixel clock. During active display it owns the video RAM for scan-out reads. During horizontal or vertical blanking it grants one-word writes to a requester. It outputs pixel data and the timing signals delayed so they stay aligned with the data.

## Interface
- FB_W, 200: frame-buffer width in stored pixels
- FB_H, 150: frame-buffer height in stored pixels
- SCALE_SH, 2: upscale shift; one stored pixel covers a 4x4 screen block (200x150 maps to 800x600)
- ADDR_W, 15: RAM address width; must hold FB_W*FB_H-1
- DATA_W, 12: pixel width (RGB444)

Ports:
- pclk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- hcount, vcount  in  11 each  screen counters from timing generator
- hsync, vsync, hblnk, vblnk  in  1 each  timing strobes from timing generator
- wr_req  in  1  write request; wr_addr/wr_data held stable while high
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  one-cycle grant pulse; request consumed
- wr_err  out  1  one-cycle pulse with wr_gnt when wr_addr >= FB_W*FB_H
- mem_addr  out  ADDR_W  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM, valid one cycle after mem_addr
- pix_data  out  DATA_W  pixel to DAC; 0 when blanked
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  inputs delayed 3 cycles

## Operation
- "active" = !hblnk && !vblnk on the current inputs.
- FSM register `own` records who owns the RAM cycle issued at the last edge: IDLE, SCAN, WRITE.
- Each edge, the next owner is chosen as follows:
  - If active, next owner is SCAN.
    - mem_addr = (vcount>>SCALE_SH)*FB_W + (hcount>>SCALE_SH), truncated to ADDR_W.
    - mem_we = 0.
  - Else if wr_req && !wr_gnt, next owner is WRITE.
    - mem_addr = wr_addr, mem_wdata = wr_data.
    - wr_gnt = 1.
    - mem_we = 1 only if wr_addr < FB_W*FB_H; otherwise mem_we = 0 and wr_err = 1.
  - Else next owner is IDLE, with mem_we = 0 and mem_addr holding its value.
- Scan always has priority. A pending write waits, with no timeout, until blanking.
- No grant is issued in the cycle while wr_gnt is high, which prevents double-consuming a held request. Maximum write rate is one per 2 cycles.
- The writer must drop wr_req or present a new address/data in the cycle after seeing wr_gnt.
- A 2-stage `own` pipeline marks which returning mem_rdata is scan data.
- pix_data = mem_rdata when the cycle issued 2 edges earlier was SCAN; otherwise pix_data = 0.
- hsync, vsync, hblnk, vblnk pass through a 3-stage shift register.
- Reset:
  - All outputs and pipeline registers go to 0; `own` = IDLE.
  - No grants while rst = 1.
  - A write with mem_we high at the reset edge is still committed by the RAM. It already received its grant.
  - A request pending at reset is re-arbitrated after reset.

## Timing
- Scan latency: inputs sampled at edge E0 → mem_addr at E0+ → mem_rdata after E1 → pix_data after E2. Inputs sampled at E0 produce pix_data registered at E2, i.e. 3 cycles from counter value to pixel; the *_out strobes carry the same delay.
- Write latency: wr_req sampled high at E0 in a blanking cycle → wr_gnt, mem_we, mem_addr and mem_wdata all high/valid in the same cycle after E0. The RAM commits at E1.
- Blanking transitions:
  - First blanking cycle: a write can be issued immediately.
  - First active cycle: scan preempts immediately, with no write in flight beyond the current cycle.
- Simultaneous wr_req and active: no grant; wr_gnt stays 0.
- Address wrap: hcount/vcount outside 0..799/0..599 are blanked, so no scan address is generated for them.

## Test plan
- Reset: rst = 1 for 2 cycles with wr_req = 1 → wr_gnt, mem_we, pix_data and all *_out are 0 throughout; first grant occurs 1 cycle after reset releases, in blanking.
- Scan address: active with hcount = 5, vcount = 9 → mem_addr = 401 and mem_we = 0 next cycle. If the RAM model returns 12'hABC, then pix_data = 12'hABC exactly 3 cycles after the sample. At hcount = 799, vcount = 599 → mem_addr = 29999.
- Write blocked during active: wr_req with addr 100, data 12'h123 at hcount = 700 → no grant until the first hblnk cycle. Then exactly one wr_gnt pulse with mem_we = 1, mem_addr = 100, mem_wdata = 12'h123. Scan resumes at the next active line, and a read-back at that address returns 12'h123.
- Held request in vblnk: wr_req held high for 10 cycles with a new address after each grant → 5 grants on alternate cycles, no duplicates.
- Out of range: wr_addr = 30000 in blanking → wr_gnt = 1 and wr_err = 1 in the same cycle, mem_we = 0, RAM unchanged.
- Alignment: hsync pulse and hblnk edge on the inputs → identical waveforms on hsync_out and hblnk_out 3 cycles later; pix_data = 0 whenever hblnk_out or vblnk_out = 1.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: scan-out owns the RAM during active video,
// one-word writes are granted during blanking; pixel and timing strobes leave aligned.
module vram_arbiter #(
    parameter int FB_W     = 200,
    parameter int FB_H     = 150,
    parameter int SCALE_SH = 2,
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 12
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [10:0]       hcount,
    input  logic [10:0]       vcount,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              hblnk,
    input  logic              vblnk,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, WRITE = 2'd2} own_t;

    localparam logic [31:0] FB_CELLS = 32'(FB_W * FB_H);

    own_t              own_q, own_d, own_p1_q;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              wr_gnt_q, wr_gnt_d;
    logic              wr_err_q, wr_err_d;
    logic [DATA_W-1:0] pix_q;
    logic [3:0]        strb_p0_q, strb_p1_q, strb_p2_q;

    logic              active;
    logic              in_range;
    logic [ADDR_W-1:0] scan_row, scan_col, scan_addr;

    assign active   = !hblnk && !vblnk;
    assign in_range = 32'(wr_addr) < FB_CELLS;
    assign scan_row = ADDR_W'(vcount >> SCALE_SH);
    assign scan_col = ADDR_W'(hcount >> SCALE_SH);
    // Address arithmetic wraps at ADDR_W bits; only active counters ever reach it.
    assign scan_addr = scan_row * ADDR_W'(FB_W) + scan_col;

    always_ff @(posedge pclk) begin
        if (rst) begin
            own_q <= IDLE;
        end else begin
            own_q <= own_d;
        end
    end

    // A grant is refused while the previous grant is still visible to the writer.
    always_comb begin
        own_d = IDLE;
        if (active) begin
            own_d = SCAN;
        end else if (wr_req && !wr_gnt_q) begin
            own_d = WRITE;
        end
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        wr_gnt_d    = 1'b0;
        wr_err_d    = 1'b0;
        case (own_d)
            SCAN: begin
                mem_addr_d = scan_addr;
            end
            WRITE: begin
                mem_addr_d  = wr_addr;
                mem_wdata_d = wr_data;
                wr_gnt_d    = 1'b1;
                mem_we_d    = in_range;
                wr_err_d    = !in_range;
            end
            default: ;
        endcase
    end

    // Issue stage, RAM-return stage, and pixel stage all share one reset.
    always_ff @(posedge pclk) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            wr_gnt_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            own_p1_q    <= IDLE;
            pix_q       <= '0;
            strb_p0_q   <= '0;
            strb_p1_q   <= '0;
            strb_p2_q   <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wr_gnt_q    <= wr_gnt_d;
            wr_err_q    <= wr_err_d;
            own_p1_q    <= own_q;
            pix_q       <= (own_p1_q == SCAN) ? mem_rdata : '0;
            strb_p0_q   <= {hsync, vsync, hblnk, vblnk};
            strb_p1_q   <= strb_p0_q;
            strb_p2_q   <= strb_p1_q;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign wr_gnt    = wr_gnt_q;
    assign wr_err    = wr_err_q;
    assign pix_data  = pix_q;
    assign hsync_out = strb_p2_q[3];
    assign vsync_out = strb_p2_q[2];
    assign hblnk_out = strb_p2_q[1];
    assign vblnk_out = strb_p2_q[0];

endmodule
